game_timer_bcd: RTL and testbench

- Parametrised game countdown timer with an integrated multiplexed 7-segment driver.
- Holds remaining time directly as packed BCD, so no divide/modulo is needed.
- Supports pause/resume, miss penalty, bonus credit with saturation, and a configurable digit count, tick rate and decimal-point position.
- Sits between game control logic (start/pause/miss/bonus pulses) and the board's 8-anode display; drives game_over back to game control.

---
 rtl/game_timer_pkg.sv | 51 +++++
 rtl/game_timer_bcd_addsub.sv | 48 ++++
 rtl/game_timer_bcd.sv | 161 ++++++++++++++++
 tb/tb_game_timer_bcd.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/game_timer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// game_timer_pkg : shared state encoding, 7-segment glyphs and BCD helpers
// Revision       : 1.0
// ---------------------------------------------------------------------------
package game_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    OVER   = 2'd3
  } state_e;

  // Glyph bit order is {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] c_SEG_0     = 7'h3F;
  localparam logic [6:0] c_SEG_1     = 7'h06;
  localparam logic [6:0] c_SEG_2     = 7'h5B;
  localparam logic [6:0] c_SEG_3     = 7'h4F;
  localparam logic [6:0] c_SEG_4     = 7'h66;
  localparam logic [6:0] c_SEG_5     = 7'h6D;
  localparam logic [6:0] c_SEG_6     = 7'h7D;
  localparam logic [6:0] c_SEG_7     = 7'h07;
  localparam logic [6:0] c_SEG_8     = 7'h7F;
  localparam logic [6:0] c_SEG_9     = 7'h6F;
  localparam logic [6:0] c_SEG_BLANK = 7'h00;

  function automatic logic bcd_is_zero(input logic [63:0] v);
    return (v == 64'd0);
  endfunction

  function automatic logic [6:0] seg_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = c_SEG_0;
      4'd1:    g = c_SEG_1;
      4'd2:    g = c_SEG_2;
      4'd3:    g = c_SEG_3;
      4'd4:    g = c_SEG_4;
      4'd5:    g = c_SEG_5;
      4'd6:    g = c_SEG_6;
      4'd7:    g = c_SEG_7;
      4'd8:    g = c_SEG_8;
      4'd9:    g = c_SEG_9;
      default: g = c_SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/game_timer_bcd_addsub.sv
`default_nettype none
// ---------------------------------------------------------------------------
// game_timer_bcd_addsub : combinational DIGITS-wide packed-BCD add/subtract
// Revision              : 1.0
// ---------------------------------------------------------------------------
module game_timer_bcd_addsub #(
  parameter int DIGITS = 6
) (
  input  logic [4*DIGITS-1:0] a_i,
  input  logic [4*DIGITS-1:0] b_i,
  input  logic                sub_i,
  output logic [4*DIGITS-1:0] res_o,
  output logic                carry_o,
  output logic                borrow_o
);

  logic       c;
  logic [4:0] t;
  logic [4:0] da;
  logic [4:0] db;

  always_comb begin
    c     = 1'b0;
    t     = '0;
    da    = '0;
    db    = '0;
    res_o = '0;
    for (int i = 0; i < DIGITS; i++) begin
      da = {1'b0, a_i[4*i +: 4]};
      db = {1'b0, b_i[4*i +: 4]};
      if (sub_i) begin
        // Digit difference lies in -10..9, so bit 4 is the sign
        t = da - db - {4'd0, c};
        c = t[4];
        if (t[4]) t = t + 5'd10;
      end else begin
        t = da + db + {4'd0, c};
        c = (t > 5'd9);
        if (c) t = t - 5'd10;
      end
      res_o[4*i +: 4] = t[3:0];
    end
    carry_o  = ~sub_i & c;
    borrow_o =  sub_i & c;
  end

endmodule
`default_nettype wire

// File: rtl/game_timer_bcd.sv
`default_nettype none
// ---------------------------------------------------------------------------
// game_timer_bcd : BCD game countdown timer with multiplexed 7-segment driver
// Revision       : 1.0
// ---------------------------------------------------------------------------
module game_timer_bcd
  import game_timer_pkg::*;
#(
  parameter int                CLK_HZ      = 50000000,
  parameter int                TICK_HZ     = 100,
  parameter int                DIGITS      = 6,
  parameter int                AN_W        = 8,
  parameter logic [4*DIGITS-1:0] INIT_BCD    = 24'h018000,
  parameter logic [4*DIGITS-1:0] PENALTY_BCD = 24'h000500,
  parameter logic [4*DIGITS-1:0] BONUS_BCD   = 24'h000300,
  parameter int                DP_POS      = 2,
  parameter int                SCAN_BITS   = 16,
  parameter int                BLANK_LZ    = 1
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic                pause_i,
  input  logic                miss_i,
  input  logic                bonus_i,
  output logic [4*DIGITS-1:0] time_bcd_o,
  output logic                running_o,
  output logic                game_over_o,
  output logic [6:0]          seg_o,
  output logic                dp_o,
  output logic [AN_W-1:0]     an_o
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [4*DIGITS-1:0] c_ONE  = {{(4*DIGITS-1){1'b0}}, 1'b1};
  localparam logic [4*DIGITS-1:0] c_ALL9 = {DIGITS{4'h9}};

  state_e              state_q, state_d;
  logic [4*DIGITS-1:0] time_q, time_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                running_q, over_q;
  logic [SCAN_BITS-1:0] scan_q;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [AN_W-1:0]     an_q, an_d;

  logic                tick;
  logic                op_sub;
  logic [4*DIGITS-1:0] op_b;
  logic [4*DIGITS-1:0] as_res;
  logic                as_carry, as_borrow;
  int                  idx;
  logic [3:0]          nib;
  logic                lz_blank;

  assign tick   = (state_q == RUN) && (pre_q == PRE_W'(DIV - 1));
  assign op_sub = miss_i | ~bonus_i;
  assign op_b   = miss_i ? PENALTY_BCD : (bonus_i ? BONUS_BCD : c_ONE);

  game_timer_bcd_addsub #(.DIGITS(DIGITS)) u_addsub (
    .a_i      (time_q),
    .b_i      (op_b),
    .sub_i    (op_sub),
    .res_o    (as_res),
    .carry_o  (as_carry),
    .borrow_o (as_borrow)
  );

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    pre_d   = pre_q;
    case (state_q)
      IDLE:   if (start_i) state_d = RUN;
      RUN: begin
        if (miss_i) begin
          if (time_q <= PENALTY_BCD) begin
            time_d  = '0;
            state_d = OVER;
          end else begin
            time_d = as_res;
          end
        end else if (bonus_i) begin
          time_d = as_carry ? c_ALL9 : as_res;
        end else if (tick) begin
          if (as_borrow || bcd_is_zero(64'(as_res))) begin
            time_d  = '0;
            state_d = OVER;
          end else begin
            time_d = as_res;
          end
        end
        // A tick that collides with miss/bonus waits at terminal count
        if (tick) pre_d = (miss_i | bonus_i) ? pre_q : '0;
        else      pre_d = pre_q + 1'b1;
        if (pause_i && state_d == RUN) state_d = PAUSED;
      end
      PAUSED: if (start_i) state_d = RUN;
      OVER:   time_d = '0;
      default: state_d = IDLE;
    endcase
    if (state_d != RUN) pre_d = '0;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      time_q    <= INIT_BCD;
      pre_q     <= '0;
      running_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      pre_q     <= pre_d;
      running_q <= (state_d == RUN);
      over_q    <= (state_d == OVER);
    end
  end

  always_comb begin
    idx      = int'(scan_q[SCAN_BITS-1 -: 3]);
    nib      = 4'(time_q >> (4 * idx));
    lz_blank = 1'b0;
    seg_d    = c_SEG_BLANK;
    an_d     = '1;
    dp_d     = (idx == DP_POS);
    if (idx < DIGITS) begin
      for (int k = 0; k < AN_W; k++) begin
        if (k == idx) an_d[k] = 1'b0;
      end
      lz_blank = (BLANK_LZ != 0) && (idx > DP_POS) &&
                 bcd_is_zero(64'(time_q >> (4 * idx)));
      seg_d    = lz_blank ? c_SEG_BLANK : seg_glyph(nib);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      scan_q <= '0;
      seg_q  <= c_SEG_BLANK;
      dp_q   <= 1'b0;
      an_q   <= '1;
    end else begin
      scan_q <= scan_q + 1'b1;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
    end
  end

  assign time_bcd_o  = time_q;
  assign running_o   = running_q;
  assign game_over_o = over_q;
  assign seg_o       = seg_q;
  assign dp_o        = dp_q;
  assign an_o        = an_q;

endmodule
`default_nettype wire

// File: tb/tb_game_timer_bcd.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_game_timer_bcd : directed bench, one DUT per starting time value
// Revision          : 1.0
// ---------------------------------------------------------------------------
module tb_game_timer_bcd;

  localparam int N = 6;
  // 0: run/reset, 1: miss->over, 2: bonus saturate, 3: pause, 4: scan, 5: collide
  localparam logic [23:0] c_INIT [N] = '{24'h018000, 24'h000100, 24'h999998,
                                         24'h010000, 24'h001234, 24'h018000};

  logic clk = 1'b0;
  logic rst;
  logic       start [N];
  logic       pause [N];
  logic       miss  [N];
  logic       bonus [N];
  logic [23:0] tbcd [N];
  logic       run_s [N];
  logic       ovr_s [N];
  logic [6:0] seg   [N];
  logic       dp    [N];
  logic [7:0] an    [N];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_dut
    game_timer_bcd #(
      .CLK_HZ(1000), .TICK_HZ(100), .DIGITS(6), .AN_W(8),
      .INIT_BCD(c_INIT[i]), .PENALTY_BCD(24'h000500), .BONUS_BCD(24'h000300),
      .DP_POS(2), .SCAN_BITS(6), .BLANK_LZ(1)
    ) u_dut (
      .clock_i     (clk),
      .reset_i     (rst),
      .start_i     (start[i]),
      .pause_i     (pause[i]),
      .miss_i      (miss[i]),
      .bonus_i     (bonus[i]),
      .time_bcd_o  (tbcd[i]),
      .running_o   (run_s[i]),
      .game_over_o (ovr_s[i]),
      .seg_o       (seg[i]),
      .dp_o        (dp[i]),
      .an_o        (an[i])
    );
  end

  typedef struct {
    int         slot;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } scan_vec_t;

  scan_vec_t vt [8];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    vt[0] = '{0, 8'hFE, 7'h66, 1'b0};
    vt[1] = '{1, 8'hFD, 7'h4F, 1'b0};
    vt[2] = '{2, 8'hFB, 7'h5B, 1'b1};
    vt[3] = '{3, 8'hF7, 7'h06, 1'b0};
    vt[4] = '{4, 8'hEF, 7'h00, 1'b0};
    vt[5] = '{5, 8'hDF, 7'h00, 1'b0};
    vt[6] = '{6, 8'hFF, 7'h00, 1'b0};
    vt[7] = '{7, 8'hFF, 7'h00, 1'b0};
    for (int i = 0; i < N; i++) begin
      start[i] = 1'b0; pause[i] = 1'b0; miss[i] = 1'b0; bonus[i] = 1'b0;
    end

    rst = 1'b1;
    step(2);
    rst = 1'b0;
    chk("reset_time", 64'(tbcd[0]), 64'h018000);
    chk("reset_running", 64'(run_s[0]), 64'd0);
    chk("reset_over", 64'(ovr_s[0]), 64'd0);
    chk("reset_an", 64'(an[0]), 64'hFF);

    // Display scan: slot s is on the outputs 8*s+4 edges after reset release
    for (int s = 0; s < 8; s++) begin
      step((s == 0) ? 4 : 8);
      chk($sformatf("scan_an_%0d", vt[s].slot), 64'(an[4]), 64'(vt[s].an));
      chk($sformatf("scan_seg_%0d", vt[s].slot), 64'(seg[4]), 64'(vt[s].seg));
      chk($sformatf("scan_dp_%0d", vt[s].slot), 64'(dp[4]), 64'(vt[s].dp));
    end
    chk("scan_time", 64'(tbcd[4]), 64'h001234);

    // Basic countdown
    start[0] = 1'b1; step(1); start[0] = 1'b0;
    chk("run_running", 64'(run_s[0]), 64'd1);
    step(29);
    chk("run_29", 64'(tbcd[0]), 64'h017998);
    step(1);
    chk("run_30", 64'(tbcd[0]), 64'h017997);
    chk("run_over", 64'(ovr_s[0]), 64'd0);

    // Miss at or below the penalty ends the game
    start[1] = 1'b1; step(1); start[1] = 1'b0;
    miss[1] = 1'b1; step(1); miss[1] = 1'b0;
    chk("miss_time", 64'(tbcd[1]), 64'd0);
    chk("miss_over", 64'(ovr_s[1]), 64'd1);
    chk("miss_running", 64'(run_s[1]), 64'd0);
    start[1] = 1'b1; bonus[1] = 1'b1; step(1); start[1] = 1'b0; bonus[1] = 1'b0;
    step(20);
    chk("over_time", 64'(tbcd[1]), 64'd0);
    chk("over_sticky", 64'(ovr_s[1]), 64'd1);
    chk("over_running", 64'(run_s[1]), 64'd0);

    // Bonus saturation
    start[2] = 1'b1; step(1); start[2] = 1'b0;
    bonus[2] = 1'b1; step(1); bonus[2] = 1'b0;
    chk("bonus_sat", 64'(tbcd[2]), 64'h999999);
    step(8);
    chk("bonus_hold", 64'(tbcd[2]), 64'h999999);
    step(1);
    chk("bonus_tick", 64'(tbcd[2]), 64'h999998);

    // Pause freezes time and clears the prescaler
    start[3] = 1'b1; step(1); start[3] = 1'b0;
    pause[3] = 1'b1; step(1); pause[3] = 1'b0;
    chk("pause_running", 64'(run_s[3]), 64'd0);
    step(20);
    miss[3] = 1'b1; bonus[3] = 1'b1; step(1); miss[3] = 1'b0; bonus[3] = 1'b0;
    step(29);
    chk("pause_frozen", 64'(tbcd[3]), 64'h010000);
    start[3] = 1'b1; step(1); start[3] = 1'b0;
    chk("resume_running", 64'(run_s[3]), 64'd1);
    step(9);
    chk("resume_9", 64'(tbcd[3]), 64'h010000);
    step(1);
    chk("resume_borrow", 64'(tbcd[3]), 64'h009999);

    // Miss + bonus on terminal count: miss wins, tick deferred one cycle
    start[5] = 1'b1; step(1); start[5] = 1'b0;
    step(9);
    chk("collide_pre", 64'(tbcd[5]), 64'h018000);
    miss[5] = 1'b1; bonus[5] = 1'b1; step(1); miss[5] = 1'b0; bonus[5] = 1'b0;
    chk("collide_miss", 64'(tbcd[5]), 64'h017500);
    step(1);
    chk("collide_tick", 64'(tbcd[5]), 64'h017499);
    step(10);
    chk("collide_next", 64'(tbcd[5]), 64'h017498);

    // Reset mid-RUN
    rst = 1'b1; step(1); rst = 1'b0;
    chk("rerst_time", 64'(tbcd[0]), 64'h018000);
    chk("rerst_running", 64'(run_s[0]), 64'd0);
    chk("rerst_over", 64'(ovr_s[1]), 64'd0);
    chk("rerst_time1", 64'(tbcd[1]), 64'h000100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
